wave_spawn_controller: RTL and testbench
========================================

Name: wave_spawn_controller

Overview:
- Datapath-side engine for the game-flow FSM's IN_PROGRESS states.
- While a stage is in progress, it spawns that stage's cars at a fixed interval through a valid/ready handshake to the car-drawing datapath.
- It tracks cars alive on the road and player lives.
- It produces the per-stage car_done feedback and the game_over feedback that the flow FSM consumes.

Parameters:
- TICKS_PER_SPAWN, 25000000, clk cycles between the end of one spawn and the next spawn request (0.5 s at 50 MHz).
- CARS_S1, 8, cars in stage 1 wave.
- CARS_S2, 12, cars in stage 2 wave.
- CARS_S3, 16, cars in stage 3 wave.
- START_LIVES, 5, lives loaded at reset.
- GAP_W, 25, width of the gap counter; must hold TICKS_PER_SPAWN-1.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- stage_1_in_progress  in  1  level from the flow FSM.
- stage_2_in_progress  in  1  level from the flow FSM.
- stage_3_in_progress  in  1  level from the flow FSM.
- spawn_ready  in  1  car datapath can accept a spawn.
- car_destroyed  in  1  one-cycle pulse: a tower killed a car.
- car_reached_end  in  1  one-cycle pulse: a car exited the map.
- spawn_valid  out  1  spawn request.
- spawn_car_id  out  5  index of the car within the wave (0..N-1).
- spawn_stage  out  2  stage of the car (1..3).
- cars_alive  out  5  cars currently on the road.
- lives  out  4  remaining lives.
- stage_1_car_done  out  1  wave 1 fully resolved (level).
- stage_2_car_done  out  1  wave 2 fully resolved (level).
- stage_3_car_done  out  1  wave 3 fully resolved (level).
- game_over  out  1  lives exhausted (sticky).
- score  out  16  see Optional Feature.

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE; all outputs 0 except lives=START_LIVES.
  - Internal to_spawn, alive and gap counter = 0.
- States: IDLE, LOAD, WAIT_GAP, SPAWN, DRAIN, DONE, OVER.
- IDLE:
  - Any stage_N_in_progress=1 → LOAD.
  - If more than one is high, priority is 1>2>3.
  - Removal pulses are ignored.
- LOAD (1 cycle):
  - Latch stage; to_spawn=CARS_SN; alive=0; id=0; gap=0.
  - → WAIT_GAP.
  - The first spawn_valid rises exactly TICKS_PER_SPAWN+1 cycles after LOAD is entered.
- WAIT_GAP:
  - gap increments each cycle.
  - At gap==TICKS_PER_SPAWN-1 → SPAWN, gap cleared.
- SPAWN:
  - spawn_valid=1; spawn_car_id and spawn_stage are held stable until spawn_ready.
  - Handshake completes in a cycle with valid&ready: to_spawn--, alive++, id++.
  - Then → DRAIN if to_spawn becomes 0, else → WAIT_GAP.
  - spawn_valid drops the following cycle.
- Removals (any of LOAD..DRAIN):
  - car_destroyed and car_reached_end each decrement alive by 1; both in one cycle decrement by 2. alive saturates at 0.
  - A removal in the same cycle as a spawn handshake nets the two.
  - car_reached_end also decrements lives, saturating at 0.
- DRAIN:
  - If to_spawn==0 and alive==0 → DONE.
- DONE:
  - stage_N_car_done=1 for the latched stage, held until that stage_N_in_progress falls, then → IDLE.
- Lives exhausted:
  - When lives reaches 0 (evaluated on the registered value), → OVER from any active state.
  - This has priority over DONE in the same cycle; car_done is never asserted with lives==0.
- OVER:
  - game_over=1, spawn_valid=0, terminal until reset.
- Abort:
  - The latched stage's in_progress falling in LOAD/WAIT_GAP/SPAWN/DRAIN → IDLE.
  - Pending spawn is withdrawn and to_spawn/alive are cleared.
  - lives persists.
- lives persists across stages; it is reloaded only by reset.
- All outputs are registered or decoded from registered state; no combinational path from inputs to outputs.

Optional Feature:
- Macro WAVE_SCORE_EN.
- When defined:
  - score += 10 per car_destroyed pulse, saturating at 16'hFFFF.
  - score += 50 on entry to DONE.
  - score is cleared only by reset.
- When undefined: score is tied to 16'd0, with no score register and no adder.

Decomposition:
- Shared package game_pkg holds:
  - state encodings (3-bit);
  - stage codes STAGE_1=2'd1, STAGE_2=2'd2, STAGE_3=2'd3;
  - per-stage car counts and START_LIVES;
  - score increments SCORE_KILL=10 and SCORE_CLEAR=50.
- One sub-module, spawn_gap_timer: GAP_W counter with clear/enable and a terminal-count pulse output.

Test Plan:
All scenarios use TICKS_PER_SPAWN=4, CARS_S1=3, START_LIVES=2.
- Normal wave:
  - Stimulus: stage_1_in_progress=1, spawn_ready=1, three car_destroyed pulses after the spawns.
  - Required: exactly 3 spawn handshakes with id 0,1,2, 5 cycles apart; cars_alive peaks at 3; stage_1_car_done=1 after the last kill, held until in_progress drops; lives=2.
- Backpressure:
  - Stimulus: spawn_ready=0 for 10 cycles during SPAWN.
  - Required: spawn_valid stays 1 with id stable; no count changes; the handshake completes on the ready cycle.
- Simultaneous events:
  - Stimulus: spawn handshake together with car_destroyed in one cycle.
  - Required: cars_alive unchanged.
  - Stimulus: car_destroyed together with car_reached_end with alive=2.
  - Required: alive=0 and lives=1 next cycle.
- Game over:
  - Stimulus: two car_reached_end pulses.
  - Required: lives=0 → game_over=1 sticky; spawn_valid=0; no car_done even if alive reaches 0 in the same cycle.
- Abort and reset:
  - Stimulus: in_progress dropped mid-WAIT_GAP.
  - Required: return to IDLE with alive=0; re-asserting in_progress restarts at id 0.
  - Stimulus: resetn=0 asserted asynchronously mid-SPAWN.
  - Required: spawn_valid=0 immediately; lives=2.
- WAVE_SCORE_EN defined:
  - Stimulus: a full 3-kill wave.
  - Required: score=80 (3×10+50).
- WAVE_SCORE_EN undefined: score=0 throughout.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game-flow definitions: spawn-controller state encodings, stage codes,
// default wave sizes, starting lives and score increments.
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_WAIT_GAP = 3'd2,
        ST_SPAWN    = 3'd3,
        ST_DRAIN    = 3'd4,
        ST_DONE     = 3'd5,
        ST_OVER     = 3'd6
    } state_e;

    localparam logic [1:0] STAGE_1 = 2'd1;
    localparam logic [1:0] STAGE_2 = 2'd2;
    localparam logic [1:0] STAGE_3 = 2'd3;

    localparam int DEFAULT_CARS_S1     = 8;
    localparam int DEFAULT_CARS_S2     = 12;
    localparam int DEFAULT_CARS_S3     = 16;
    localparam int DEFAULT_START_LIVES = 5;

    localparam int SCORE_KILL  = 10;
    localparam int SCORE_CLEAR = 50;

endpackage

// File: rtl/spawn_gap_timer.sv
// Free-running gap counter with synchronous clear/enable; tc pulses on the cycle
// the count sits at LAST while enabled.
module spawn_gap_timer #(
    parameter int W    = 25,
    parameter int LAST = 24999999
) (
    input  logic clk,
    input  logic resetn,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [W-1:0] LAST_V = W'(LAST);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = en && (cnt == LAST_V);

endmodule

// File: rtl/wave_spawn_controller.sv
// Wave engine for the flow FSM's IN_PROGRESS states: spawns cars at a fixed gap,
// tracks cars alive and lives, reports per-stage car_done and game_over.
// Optional scoring is built when WAVE_SCORE_EN is defined.
module wave_spawn_controller
    import game_pkg::*;
#(
    parameter int TICKS_PER_SPAWN = 25000000,
    parameter int CARS_S1         = DEFAULT_CARS_S1,
    parameter int CARS_S2         = DEFAULT_CARS_S2,
    parameter int CARS_S3         = DEFAULT_CARS_S3,
    parameter int START_LIVES     = DEFAULT_START_LIVES,
    parameter int GAP_W           = 25
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        stage_1_in_progress,
    input  logic        stage_2_in_progress,
    input  logic        stage_3_in_progress,
    input  logic        spawn_ready,
    input  logic        car_destroyed,
    input  logic        car_reached_end,
    output logic        spawn_valid,
    output logic [4:0]  spawn_car_id,
    output logic [1:0]  spawn_stage,
    output logic [4:0]  cars_alive,
    output logic [3:0]  lives,
    output logic        stage_1_car_done,
    output logic        stage_2_car_done,
    output logic        stage_3_car_done,
    output logic        game_over,
    output logic [15:0] score,
    output logic [2:0]  dbg_state
);

    // Handshake: spawn_valid is high for the whole SPAWN state with id/stage held;
    // a car is transferred on every rising edge where spawn_valid && spawn_ready.
    state_e      state, state_nx;
    logic [1:0]  stage_q, stage_nx;
    logic [4:0]  to_spawn, to_spawn_nx;
    logic [4:0]  alive, alive_nx;
    logic [4:0]  car_id, car_id_nx;
    logic [3:0]  lives_q, lives_nx;
    logic        fire, active, stage_live, lives_dec, gap_tc;
    logic [5:0]  alive_sum, alive_net, removals;
    logic [4:0]  wave_len;

    spawn_gap_timer #(.W(GAP_W), .LAST(TICKS_PER_SPAWN - 1)) u_gap (
        .clk    (clk),
        .resetn (resetn),
        .clr    ((state != ST_WAIT_GAP) || gap_tc),
        .en     (state == ST_WAIT_GAP),
        .tc     (gap_tc)
    );

    always_comb begin
        active     = (state == ST_LOAD) || (state == ST_WAIT_GAP) ||
                     (state == ST_SPAWN) || (state == ST_DRAIN);
        fire       = (state == ST_SPAWN) && spawn_ready;
        removals   = {5'd0, car_destroyed} + {5'd0, car_reached_end};
        alive_sum  = {1'b0, alive} + {5'd0, fire};
        alive_net  = (alive_sum > removals) ? (alive_sum - removals) : 6'd0;
        lives_dec  = active && car_reached_end && (lives_q != 4'd0);
        case (stage_q)
            STAGE_1: begin stage_live = stage_1_in_progress; wave_len = 5'(CARS_S1); end
            STAGE_2: begin stage_live = stage_2_in_progress; wave_len = 5'(CARS_S2); end
            STAGE_3: begin stage_live = stage_3_in_progress; wave_len = 5'(CARS_S3); end
            default: begin stage_live = 1'b0;                wave_len = 5'd0;        end
        endcase
    end

    always_comb begin
        state_nx    = state;
        stage_nx    = stage_q;
        to_spawn_nx = to_spawn;
        alive_nx    = alive;
        car_id_nx   = car_id;
        lives_nx    = lives_q - {3'd0, lives_dec};
        if (active) begin
            alive_nx = alive_net[4:0];
        end
        case (state)
            ST_IDLE: begin
                if (stage_1_in_progress) begin
                    stage_nx = STAGE_1;
                    state_nx = ST_LOAD;
                end else if (stage_2_in_progress) begin
                    stage_nx = STAGE_2;
                    state_nx = ST_LOAD;
                end else if (stage_3_in_progress) begin
                    stage_nx = STAGE_3;
                    state_nx = ST_LOAD;
                end
            end
            ST_LOAD: begin
                to_spawn_nx = wave_len;
                alive_nx    = 5'd0;
                car_id_nx   = 5'd0;
                state_nx    = ST_WAIT_GAP;
            end
            ST_WAIT_GAP: begin
                if (gap_tc) state_nx = ST_SPAWN;
            end
            ST_SPAWN: begin
                if (fire) begin
                    to_spawn_nx = to_spawn - 5'd1;
                    car_id_nx   = car_id + 5'd1;
                    state_nx    = (to_spawn == 5'd1) ? ST_DRAIN : ST_WAIT_GAP;
                end
            end
            ST_DRAIN: begin
                // Never enter DONE on the cycle the last life is lost.
                if ((to_spawn == 5'd0) && (alive == 5'd0) && (lives_nx != 4'd0))
                    state_nx = ST_DONE;
            end
            ST_DONE: begin
                if (!stage_live) state_nx = ST_IDLE;
            end
            default: state_nx = ST_OVER;
        endcase
        if (active && !stage_live) begin
            state_nx    = ST_IDLE;
            to_spawn_nx = 5'd0;
            alive_nx    = 5'd0;
        end
        if ((lives_q == 4'd0) && (state != ST_OVER)) begin
            state_nx = ST_OVER;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= ST_IDLE;
            stage_q  <= 2'd0;
            to_spawn <= 5'd0;
            alive    <= 5'd0;
            car_id   <= 5'd0;
            lives_q  <= 4'(START_LIVES);
        end else begin
            state    <= state_nx;
            stage_q  <= stage_nx;
            to_spawn <= to_spawn_nx;
            alive    <= alive_nx;
            car_id   <= car_id_nx;
            lives_q  <= lives_nx;
        end
    end

`ifdef WAVE_SCORE_EN
    logic [15:0] score_q;
    logic [16:0] score_sum;

    always_comb begin
        score_sum = {1'b0, score_q}
                  + ((active && car_destroyed) ? 17'(SCORE_KILL) : 17'd0)
                  + (((state == ST_DRAIN) && (state_nx == ST_DONE)) ? 17'(SCORE_CLEAR) : 17'd0);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            score_q <= 16'd0;
        end else begin
            score_q <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
        end
    end

    assign score = score_q;
`else
    assign score = 16'd0;
`endif

    assign spawn_valid      = (state == ST_SPAWN);
    assign spawn_car_id     = car_id;
    assign spawn_stage      = stage_q;
    assign cars_alive       = alive;
    assign lives            = lives_q;
    assign stage_1_car_done = (state == ST_DONE) && (stage_q == STAGE_1);
    assign stage_2_car_done = (state == ST_DONE) && (stage_q == STAGE_2);
    assign stage_3_car_done = (state == ST_DONE) && (stage_q == STAGE_3);
    assign game_over        = (state == ST_OVER);
    assign dbg_state        = state;

endmodule

// File: tb/tb_wave_spawn_controller.sv
// Directed bench for wave_spawn_controller with TICKS_PER_SPAWN=4, CARS_S1=3,
// START_LIVES=2; score expectations follow WAVE_SCORE_EN.
module tb_wave_spawn_controller;
    import game_pkg::*;

`ifdef WAVE_SCORE_EN
    localparam bit SCORE_ON = 1'b1;
`else
    localparam bit SCORE_ON = 1'b0;
`endif

    logic        clk;
    logic        resetn;
    logic        stage_1_in_progress, stage_2_in_progress, stage_3_in_progress;
    logic        spawn_ready, car_destroyed, car_reached_end;
    logic        spawn_valid;
    logic [4:0]  spawn_car_id;
    logic [1:0]  spawn_stage;
    logic [4:0]  cars_alive;
    logic [3:0]  lives;
    logic        stage_1_car_done, stage_2_car_done, stage_3_car_done;
    logic        game_over;
    logic [15:0] score;
    logic [2:0]  dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_score = 0;
    logic [4:0] exp_q[$];

    wave_spawn_controller #(
        .TICKS_PER_SPAWN (4),
        .CARS_S1         (3),
        .START_LIVES     (2),
        .GAP_W           (3)
    ) dut (
        .clk                 (clk),
        .resetn              (resetn),
        .stage_1_in_progress (stage_1_in_progress),
        .stage_2_in_progress (stage_2_in_progress),
        .stage_3_in_progress (stage_3_in_progress),
        .spawn_ready         (spawn_ready),
        .car_destroyed       (car_destroyed),
        .car_reached_end     (car_reached_end),
        .spawn_valid         (spawn_valid),
        .spawn_car_id        (spawn_car_id),
        .spawn_stage         (spawn_stage),
        .cars_alive          (cars_alive),
        .lives               (lives),
        .stage_1_car_done    (stage_1_car_done),
        .stage_2_car_done    (stage_2_car_done),
        .stage_3_car_done    (stage_3_car_done),
        .game_over           (game_over),
        .score               (score),
        .dbg_state           (dbg_state)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: timeout got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input bit destroyed, input bit reached);
        car_destroyed   = destroyed;
        car_reached_end = reached;
        tick(1);
        car_destroyed   = 1'b0;
        car_reached_end = 1'b0;
    endtask

    function automatic int sc(input int v);
        return SCORE_ON ? v : 0;
    endfunction

    // Scoreboard: each completed handshake must match the next expected car id.
    always @(negedge clk) begin
        if (resetn && spawn_valid && spawn_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_handshake", {27'd0, spawn_car_id}, 32'hFFFF_FFFF);
            end else begin
                check("handshake_id", {27'd0, spawn_car_id}, {27'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        resetn = 1'b0;
        stage_1_in_progress = 1'b0;
        stage_2_in_progress = 1'b0;
        stage_3_in_progress = 1'b0;
        spawn_ready = 1'b0;
        car_destroyed = 1'b0;
        car_reached_end = 1'b0;
        #12;
        check("rst_valid", spawn_valid, 0);
        check("rst_lives", lives, 2);
        check("rst_alive", cars_alive, 0);
        check("rst_state", dbg_state, 32'(ST_IDLE));
        check("rst_game_over", game_over, 0);
        check("rst_score", score, 0);
        check("rst_stage", spawn_stage, 0);
        @(posedge clk);
        #1;
        resetn = 1'b1;

        // Normal wave
        exp_q.push_back(5'd0); exp_q.push_back(5'd1); exp_q.push_back(5'd2);
        stage_1_in_progress = 1'b1;
        spawn_ready = 1'b1;
        tick(1);
        check("w1_load", dbg_state, 32'(ST_LOAD));
        tick(4);
        check("w1_no_early_valid", spawn_valid, 0);
        check("w1_wait_state", dbg_state, 32'(ST_WAIT_GAP));
        tick(1);
        check("w1_valid0", spawn_valid, 1);
        check("w1_id0", spawn_car_id, 0);
        check("w1_stage", spawn_stage, 1);
        tick(1);
        check("w1_valid_drop", spawn_valid, 0);
        check("w1_alive1", cars_alive, 1);
        tick(4);
        check("w1_valid1", spawn_valid, 1);
        check("w1_id1", spawn_car_id, 1);
        tick(1);
        check("w1_alive2", cars_alive, 2);
        tick(4);
        check("w1_valid2", spawn_valid, 1);
        check("w1_id2", spawn_car_id, 2);
        tick(1);
        check("w1_alive3", cars_alive, 3);
        check("w1_drain", dbg_state, 32'(ST_DRAIN));
        for (int i = 0; i < 3; i++) begin
            pulse(1'b1, 1'b0);
            check("w1_kill_alive", cars_alive, 32'(2 - i));
            check("w1_no_done_yet", stage_1_car_done, 0);
        end
        tick(1);
        exp_score = sc(80);
        check("w1_done", stage_1_car_done, 1);
        check("w1_done_s2", stage_2_car_done, 0);
        check("w1_lives", lives, 2);
        check("w1_score", score, 32'(exp_score));
        tick(3);
        check("w1_done_held", stage_1_car_done, 1);
        stage_1_in_progress = 1'b0;
        tick(1);
        check("w1_done_clear", stage_1_car_done, 0);
        check("w1_idle", dbg_state, 32'(ST_IDLE));

        // Backpressure and simultaneous events
        exp_q.push_back(5'd0); exp_q.push_back(5'd1); exp_q.push_back(5'd2);
        spawn_ready = 1'b0;
        stage_1_in_progress = 1'b1;
        tick(6);
        check("bp_valid", spawn_valid, 1);
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check("bp_hold_valid", spawn_valid, 1);
            check("bp_hold_id", spawn_car_id, 0);
            check("bp_hold_alive", cars_alive, 0);
        end
        spawn_ready = 1'b1;
        tick(1);
        check("bp_accept_alive", cars_alive, 1);
        check("bp_accept_id", spawn_car_id, 1);
        check("bp_accept_valid", spawn_valid, 0);
        tick(4);
        check("sim_valid1", spawn_valid, 1);
        pulse(1'b1, 1'b0);
        check("sim_spawn_kill_alive", cars_alive, 1);
        check("sim_spawn_kill_id", spawn_car_id, 2);
        tick(4);
        check("sim_valid2", spawn_valid, 1);
        tick(1);
        check("sim_alive2", cars_alive, 2);
        pulse(1'b1, 1'b1);
        check("sim_both_alive", cars_alive, 0);
        check("sim_both_lives", lives, 1);
        tick(1);
        exp_score = sc(150);
        check("w2_done", stage_1_car_done, 1);
        check("w2_score", score, 32'(exp_score));
        stage_1_in_progress = 1'b0;
        tick(1);
        check("w2_idle", dbg_state, 32'(ST_IDLE));

        // Abort mid-WAIT_GAP, then restart
        exp_q.push_back(5'd0);
        stage_1_in_progress = 1'b1;
        tick(7);
        check("ab_alive1", cars_alive, 1);
        tick(2);
        check("ab_wait", dbg_state, 32'(ST_WAIT_GAP));
        stage_1_in_progress = 1'b0;
        tick(1);
        check("ab_idle", dbg_state, 32'(ST_IDLE));
        check("ab_alive0", cars_alive, 0);
        check("ab_lives", lives, 1);
        spawn_ready = 1'b0;
        stage_1_in_progress = 1'b1;
        tick(6);
        check("ab_restart_valid", spawn_valid, 1);
        check("ab_restart_id", spawn_car_id, 0);

        // Asynchronous reset mid-SPAWN
        resetn = 1'b0;
        #1;
        check("ar_valid", spawn_valid, 0);
        check("ar_lives", lives, 2);
        check("ar_state", dbg_state, 32'(ST_IDLE));
        check("ar_score", score, 0);
        stage_1_in_progress = 1'b0;
        tick(2);
        resetn = 1'b1;
        exp_score = 0;

        // Game over
        exp_q.push_back(5'd0); exp_q.push_back(5'd1); exp_q.push_back(5'd2);
        spawn_ready = 1'b1;
        stage_1_in_progress = 1'b1;
        tick(7);
        check("go_alive1", cars_alive, 1);
        tick(5);
        check("go_alive2", cars_alive, 2);
        tick(5);
        check("go_alive3", cars_alive, 3);
        pulse(1'b1, 1'b0);
        exp_score = sc(10);
        check("go_kill_alive", cars_alive, 2);
        pulse(1'b0, 1'b1);
        check("go_end1_alive", cars_alive, 1);
        check("go_end1_lives", lives, 1);
        pulse(1'b0, 1'b1);
        check("go_end2_alive", cars_alive, 0);
        check("go_end2_lives", lives, 0);
        check("go_end2_no_done", stage_1_car_done, 0);
        tick(1);
        check("go_over", game_over, 1);
        check("go_over_state", dbg_state, 32'(ST_OVER));
        check("go_no_done", stage_1_car_done, 0);
        check("go_valid", spawn_valid, 0);
        stage_1_in_progress = 1'b0;
        tick(3);
        stage_1_in_progress = 1'b1;
        tick(7);
        check("go_sticky", game_over, 1);
        check("go_sticky_valid", spawn_valid, 0);
        check("go_sticky_lives", lives, 0);
        check("go_score", score, 32'(exp_score));
        check("handshakes_all_seen", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
